// File: rtl/cpu_clock_ctrl_if.sv
// Processor-clock controller bundle.
//   key_n      : raw active-low step push-button (master -> controller)
//   run        : raw free-run / single-step switch (master -> controller)
//   cpuclk     : registered processor clock (controller -> master)
//   tick       : one-clk pulse in the cycle cpuclk rises (controller -> master)
//   busy       : controller is producing a pulse (controller -> master)
//   step_count : number of cpuclk rising edges since reset (controller -> master)
interface cpu_clock_ctrl_if;
    localparam int unsigned STEP_W = 16;

    logic              key_n;
    logic              run;
    logic              cpuclk;
    logic              tick;
    logic              busy;
    logic [STEP_W-1:0] step_count;

    modport master (
        output key_n,
        output run,
        input  cpuclk,
        input  tick,
        input  busy,
        input  step_count
    );

    modport slave (
        input  key_n,
        input  run,
        output cpuclk,
        output tick,
        output busy,
        output step_count
    );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// Processor clock generator with free-run and debounced single-step modes.
//   clk   : 50 MHz board clock, the only clock in the block
//   reset : synchronous active-high reset
//   bus   : cpu_clock_ctrl_if.slave (key_n, run in; cpuclk, tick, busy, step_count out)
// Parameters:
//   DIV_HALF : clk cycles cpuclk spends high and low (1..2^26-1)
//   DEBOUNCE : cycles a new key level must hold before it is accepted (1..2^24-1)
// Optional feature macro: CPU_CLOCK_STEP_COUNTER_EN
//   defined   -> step_count counts cpuclk rising edges (wraps at 16 bits)
//   undefined -> no counter register, step_count tied to zero
module cpu_clock_ctrl #(
    parameter int unsigned DIV_HALF = 25000000,
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    cpu_clock_ctrl_if.slave  bus
);

    localparam int unsigned PHASE_W = 26;
    localparam int unsigned DEB_W   = 24;
    localparam int unsigned STEP_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    logic               key_meta_q, key_meta_d;
    logic               key_sync_q, key_sync_d;
    logic               run_meta_q, run_meta_d;
    logic               run_sync_q, run_sync_d;
    logic               stable_q,   stable_d;
    logic [DEB_W-1:0]   deb_cnt_q,  deb_cnt_d;
    logic               press_q,    press_d;
    state_e             state_q,    state_d;
    logic [PHASE_W-1:0] phase_q,    phase_d;
    logic               cpuclk_q,   cpuclk_d;
    logic               tick_q,     tick_d;
    logic               busy_q,     busy_d;
    logic               pressed_c;
    logic               phase_end_c;

    assign pressed_c   = ~key_sync_q;
    assign phase_end_c = (phase_q == PHASE_W'(DIV_HALF - 1));

    // Synchronizers, debouncer, press-edge detector and pulse FSM
    always_comb begin
        key_meta_d = bus.key_n;
        key_sync_d = key_meta_q;
        run_meta_d = bus.run;
        run_sync_d = run_meta_q;

        // Counter only runs while the synced level disagrees with the accepted one
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (pressed_c != stable_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE - 1)) begin
                stable_d = pressed_c;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        // Only the released->pressed transition produces an event
        press_d = stable_d & ~stable_q;

        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                // Press events are consumed only here, so presses while busy are lost
                if (run_sync_q || press_q) begin
                    state_d = HIGH;
                    phase_d = '0;
                end
            end
            HIGH: begin
                if (phase_end_c) begin
                    state_d = LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            LOW: begin
                // run is sampled only at the end of a full period: no runt pulses
                if (phase_end_c) begin
                    state_d = run_sync_q ? HIGH : IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        cpuclk_d = (state_d == HIGH);
        tick_d   = (state_d == HIGH) && (state_q != HIGH);
        busy_d   = (state_d != IDLE);
    end

    // State registers; synchronizers reset to the released / single-step levels
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            run_meta_q <= 1'b0;
            run_sync_q <= 1'b0;
            stable_q   <= 1'b0;
            deb_cnt_q  <= '0;
            press_q    <= 1'b0;
            state_q    <= IDLE;
            phase_q    <= '0;
            cpuclk_q   <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            run_meta_q <= run_meta_d;
            run_sync_q <= run_sync_d;
            stable_q   <= stable_d;
            deb_cnt_q  <= deb_cnt_d;
            press_q    <= press_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            cpuclk_q   <= cpuclk_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.cpuclk = cpuclk_q;
    assign bus.tick   = tick_q;
    assign bus.busy   = busy_q;

`ifdef CPU_CLOCK_STEP_COUNTER_EN
    logic [STEP_W-1:0] step_count_q, step_count_d;

    // Counts in step with tick so step_count already includes the edge being flagged
    always_comb begin
        step_count_d = step_count_q + STEP_W'(tick_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_count_q <= '0;
        end else begin
            step_count_q <= step_count_d;
        end
    end

    assign bus.step_count = step_count_q;
`else
    assign bus.step_count = '0;
`endif

endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 Parameter DIV_HALF, default 25000000, number of clk cycles cpuclk stays high and stays low (range 1..2^26-1).
REQ-002 Parameter DEBOUNCE, default 1000000, consecutive synchronized clk cycles a key level must hold before it is accepted (range 1..2^24-1).
REQ-003 clk  input  1  free-running board clock (50 MHz); the only clock in the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_n  input  1  raw, asynchronous, active-low step push-button.
REQ-006 run  input  1  raw, asynchronous switch; 1 = free-run mode, 0 = single-step mode.
REQ-007 cpuclk  output  1  registered processor clock; drives the processor clk input downstream.
REQ-008 tick  output  1  one-clk pulse asserted in the same cycle cpuclk goes 0->1.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 step_count  output  16  count of cpuclk rising edges since reset.

Function
REQ-011 key_n and run SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Debouncer SHALL hold a stable "pressed" level; a counter increments each cycle the synced ~key_n differs from stable and clears whenever they match.
REQ-013 When the counter reaches DEBOUNCE, stable SHALL take the new level in that cycle and the counter SHALL clear.
REQ-014 A press event SHALL be a one-cycle internal pulse in the cycle after stable changes 0->1; release (1->0) SHALL generate no event.
REQ-015 FSM states: IDLE (cpuclk=0), HIGH (cpuclk=1), LOW (cpuclk=0); a phase counter counts cycles spent in HIGH/LOW.
REQ-016 IDLE->HIGH when synced run=1, or when synced run=0 and a press event occurs; tick asserted in the cycle cpuclk becomes 1.
REQ-017 HIGH->LOW after exactly DIV_HALF cycles in HIGH.
REQ-018 LOW->HIGH after DIV_HALF cycles if synced run=1 at that cycle, else LOW->IDLE.
REQ-019 Press events while busy=1 SHALL be discarded, not queued.
REQ-020 Run 1->0 mid-period SHALL let the current HIGH and LOW phases complete in full (no runt pulses), then enter IDLE.
REQ-021 In run mode cpuclk period SHALL be exactly 2*DIV_HALF clk cycles, 50% duty.
REQ-022 Single step SHALL produce exactly one cpuclk pulse of DIV_HALF high cycles followed by DIV_HALF low cycles.
REQ-023 step_count SHALL increment by 1 on each tick, wrapping 0xFFFF->0x0000.

Reset
REQ-024 reset SHALL force FSM=IDLE, cpuclk=0, tick=0, busy=0, step_count=0, synchronizer flops=released/step levels (key synced=1, run synced=0), debounce stable=0, all counters=0.
REQ-025 reset asserted mid-pulse SHALL drop cpuclk to 0 on the next clk edge; no tick while reset=1.
REQ-026 After reset deassertion, first possible tick SHALL occur no earlier than 3 cycles later (synchronizer latency).

Configuration
REQ-027 Macro CPU_CLOCK_STEP_COUNTER_EN: defined -> step_count implemented per REQ-023; undefined -> counter register omitted and step_count tied to 16'h0000.

Verification (DIV_HALF=4, DEBOUNCE=8)
REQ-028 reset=1 3 cycles, run=1 -> first tick 3 cycles after reset release; cpuclk 4 high/4 low repeating; step_count=5 after 5 ticks.
REQ-029 run=0, key_n low for 20 cycles then high -> exactly one tick, cpuclk high 4 cycles then low 4, busy returns 0, step_count=1.
REQ-030 run=0, key_n bounces (low 3, high 2, low 3, high) -> no tick, step_count stays 0.
REQ-031 run=0, second valid press accepted while busy=1 -> ignored; only 1 tick total.
REQ-032 run=1 then run=0 on 2nd cycle of HIGH -> HIGH completes 4 cycles, LOW 4 cycles, IDLE; no further tick.
REQ-033 Preload 0xFFFF (force) then one step -> step_count=0x0000; with macro undefined step_count=0 throughout.
